rr_wrr_arb: RTL and testbench

Weighted round-robin arbiter with a registered grant and a valid/ack handshake. It is the parametrised successor of the team's single-pointer round-robin arbiter. Each requester may hold priority for up to weight+1 consecutive accepted grants before the pointer moves past it. It sits between REQCNT request sources and one shared resource (bus port, FIFO write side, DMA channel).

---
 rtl/rr_arb_pkg.sv | 31 +++
 rtl/rr_wrr_arb_if.sv | 23 ++
 rtl/rr_ring_sel.sv | 35 +++
 rtl/rr_wrr_arb.sv | 115 +++++++++++
 tb/tb_rr_wrr_arb.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter family.
// Pointer wrap and weight-field extraction live here so other arbiters can reuse them.
package rr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Upper bound on the packed weight vector handled by weight_of.
    localparam int unsigned WVEC_MAX = 256;

    // Explicit wrap so non-power-of-2 requester counts never reach unused indices.
    function automatic int next_ptr(input int idx, input int reqcnt);
        return (idx >= reqcnt - 1) ? 0 : idx + 1;
    endfunction

    function automatic int unsigned weight_of(input logic [WVEC_MAX-1:0] weights,
                                              input int unsigned n,
                                              input int unsigned wwidth);
        int unsigned w;
        w = 0;
        for (int unsigned b = 0; b < wwidth; b++) begin
            if (weights[n*wwidth + b]) begin
                w = w | (32'd1 << b);
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_wrr_arb_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_wrr_arb_if #(
    parameter int REQCNT   = 5,
    parameter int REQWIDTH = $clog2(REQCNT),
    parameter int WWIDTH   = 4
);
    logic [REQCNT-1:0]        req_i;
    logic [REQCNT*WWIDTH-1:0] weight_i;
    logic                     gnt_ack_i;
    logic                     gnt_val_o;
    logic [REQWIDTH-1:0]      gnt_num_o;
    logic [REQCNT-1:0]        gnt_onehot_o;

    modport master (
        output req_i, weight_i, gnt_ack_i,
        input  gnt_val_o, gnt_num_o, gnt_onehot_o
    );

    modport slave (
        input  req_i, weight_i, gnt_ack_i,
        output gnt_val_o, gnt_num_o, gnt_onehot_o
    );
endinterface

// File: rtl/rr_ring_sel.sv
// Combinational ring priority search: first set bit of req at or above ptr,
// wrapping from REQCNT-1 back to 0.
module rr_ring_sel #(
    parameter int REQCNT   = 5,
    parameter int REQWIDTH = $clog2(REQCNT)
) (
    input  logic [REQCNT-1:0]   req,
    input  logic [REQWIDTH-1:0] ptr,
    output logic                any_o,
    output logic [REQWIDTH-1:0] idx_o,
    output logic [REQCNT-1:0]   onehot_o
);
    logic [REQWIDTH:0] pos;

    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        pos   = '0;
        for (int unsigned k = 0; k < REQCNT; k++) begin
            pos = {1'b0, ptr} + (REQWIDTH+1)'(k);
            if (pos >= (REQWIDTH+1)'(REQCNT)) begin
                pos = pos - (REQWIDTH+1)'(REQCNT);
            end
            if (!any_o && req[pos[REQWIDTH-1:0]]) begin
                any_o = 1'b1;
                idx_o = pos[REQWIDTH-1:0];
            end
        end
    end

    for (genvar gi = 0; gi < REQCNT; gi++) begin : g_onehot
        assign onehot_o[gi] = any_o && (idx_o == REQWIDTH'(gi));
    end

endmodule

// File: rtl/rr_wrr_arb.sv
// Weighted round-robin arbiter: each owner keeps priority for weight+1 accepted
// grants; the grant is registered and held until acknowledged.
module rr_wrr_arb
    import rr_arb_pkg::*;
#(
    parameter int REQCNT   = 5,
    parameter int REQWIDTH = $clog2(REQCNT),
    parameter int WWIDTH   = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    rr_wrr_arb_if.slave  bus
);
    state_t              state_reg, state_next;
    logic [REQWIDTH-1:0] ptr_reg, ptr_next;
    logic [WWIDTH-1:0]   cnt_reg, cnt_next;
    logic                gnt_val_reg, gnt_val_next;
    logic [REQWIDTH-1:0] gnt_num_reg, gnt_num_next;
    logic [REQCNT-1:0]   gnt_onehot_reg, gnt_onehot_next;

    logic                accept;
    logic                turn_end;
    logic                sel_any;
    logic [REQWIDTH-1:0] sel_idx;
    logic [REQCNT-1:0]   sel_onehot;

    assign accept = (state_reg == GRANT) && bus.gnt_ack_i;

    // ">=" so that a weight lowered below the running count still ends the turn.
    assign turn_end = (32'(cnt_reg) >= weight_of(WVEC_MAX'(bus.weight_i), 32'(gnt_num_reg), WWIDTH))
                   || !bus.req_i[gnt_num_reg];

    always_comb begin
        ptr_next = ptr_reg;
        cnt_next = cnt_reg;
        if (accept) begin
            if (turn_end) begin
                cnt_next = '0;
                ptr_next = REQWIDTH'(next_ptr(int'(gnt_num_reg), REQCNT));
            end else begin
                cnt_next = cnt_reg + 1'b1;
                ptr_next = gnt_num_reg;
            end
        end
    end

    // The search runs from the already-updated pointer so an ack yields the next grant at once.
    rr_ring_sel #(
        .REQCNT  (REQCNT),
        .REQWIDTH(REQWIDTH)
    ) u_sel (
        .req     (bus.req_i),
        .ptr     (ptr_next),
        .any_o   (sel_any),
        .idx_o   (sel_idx),
        .onehot_o(sel_onehot)
    );

    always_comb begin
        state_next      = state_reg;
        gnt_val_next    = gnt_val_reg;
        gnt_num_next    = gnt_num_reg;
        gnt_onehot_next = gnt_onehot_reg;
        case (state_reg)
            IDLE: begin
                if (sel_any) begin
                    state_next      = GRANT;
                    gnt_val_next    = 1'b1;
                    gnt_num_next    = sel_idx;
                    gnt_onehot_next = sel_onehot;
                end
            end
            GRANT: begin
                if (accept) begin
                    if (sel_any) begin
                        gnt_num_next    = sel_idx;
                        gnt_onehot_next = sel_onehot;
                    end else begin
                        state_next      = IDLE;
                        gnt_val_next    = 1'b0;
                        gnt_onehot_next = '0;
                    end
                end
            end
            default: begin
                state_next      = IDLE;
                gnt_val_next    = 1'b0;
                gnt_onehot_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            ptr_reg        <= '0;
            cnt_reg        <= '0;
            gnt_val_reg    <= 1'b0;
            gnt_num_reg    <= '0;
            gnt_onehot_reg <= '0;
        end else begin
            state_reg      <= state_next;
            ptr_reg        <= ptr_next;
            cnt_reg        <= cnt_next;
            gnt_val_reg    <= gnt_val_next;
            gnt_num_reg    <= gnt_num_next;
            gnt_onehot_reg <= gnt_onehot_next;
        end
    end

    assign bus.gnt_val_o    = gnt_val_reg;
    assign bus.gnt_num_o    = gnt_num_reg;
    assign bus.gnt_onehot_o = gnt_onehot_reg;

endmodule

// File: tb/tb_rr_wrr_arb.sv
// Directed bench for rr_wrr_arb with REQCNT=5, WWIDTH=4; expected grants are hand-computed.
module tb_rr_wrr_arb;
    logic clk;
    logic rst;
    int   total;
    int   passed;

    rr_wrr_arb_if #(.REQCNT(5), .WWIDTH(4)) bus ();

    rr_wrr_arb #(.REQCNT(5), .WWIDTH(4)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_grant(input string tag, input int exp_num);
        logic [4:0] exp_oh;
        exp_oh = 5'd1 << exp_num;
        $display("txn %s: gnt_val=%0d gnt_num=%0d gnt_onehot=%b", tag,
                 bus.gnt_val_o, bus.gnt_num_o, bus.gnt_onehot_o);
        chk({tag, " val"}, 32'(bus.gnt_val_o), 32'd1);
        chk({tag, " num"}, 32'(bus.gnt_num_o), 32'(exp_num));
        chk({tag, " onehot"}, 32'(bus.gnt_onehot_o), 32'(exp_oh));
    endtask

    task automatic chk_idle(input string tag);
        $display("txn %s: gnt_val=%0d gnt_onehot=%b", tag, bus.gnt_val_o, bus.gnt_onehot_o);
        chk({tag, " val"}, 32'(bus.gnt_val_o), 32'd0);
        chk({tag, " onehot"}, 32'(bus.gnt_onehot_o), 32'd0);
    endtask

    // Called between clock edges; reset is asynchronous so no edge is needed.
    task automatic do_reset();
        rst = 1'b1;
        bus.req_i     = '0;
        bus.gnt_ack_i = 1'b0;
        #2;
        rst = 1'b0;
    endtask

    function automatic logic [19:0] wset(input logic [19:0] base, input int n, input int v);
        logic [19:0] r;
        r = base;
        r[n*4 +: 4] = 4'(v);
        return r;
    endfunction

    // Pointer must stay within 0..4 for a 5-requester ring.
    always @(negedge clk) begin
        if (!rst) begin
            total++;
            assert (dut.ptr_reg < 3'd5) passed++;
            else $error("FAIL ptr_range observed=%0d expected=<5", dut.ptr_reg);
        end
    end

    initial begin
        int seq_rr[6];
        int seq_w[8];
        total  = 0;
        passed = 0;
        seq_rr = '{0, 1, 2, 3, 4, 0};
        seq_w  = '{0, 1, 1, 1, 0, 1, 1, 1};

        rst           = 1'b1;
        bus.req_i     = '0;
        bus.weight_i  = '0;
        bus.gnt_ack_i = 1'b0;
        tick();
        tick();
        chk_idle("reset");
        chk("reset num", 32'(bus.gnt_num_o), 32'd0);
        chk("reset ptr", 32'(dut.ptr_reg), 32'd0);
        chk("reset cnt", 32'(dut.cnt_reg), 32'd0);

        // Reset asserted while a grant is outstanding drops it immediately.
        rst = 1'b0;
        bus.req_i = 5'b01000;
        tick();
        chk_grant("pre_reset", 3);
        rst = 1'b1;
        #1;
        chk_idle("async_reset");
        rst = 1'b0;
        bus.req_i = '0;
        tick();
        chk_idle("after_reset");
        chk("after_reset num", 32'(bus.gnt_num_o), 32'd0);
        bus.req_i = 5'b00100;
        tick();
        chk_grant("req_latency", 2);
        bus.req_i = '0;
        bus.gnt_ack_i = 1'b1;
        tick();
        chk_idle("drain");

        // Plain round-robin with all weights zero.
        do_reset();
        bus.weight_i  = '0;
        bus.req_i     = 5'b11111;
        bus.gnt_ack_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_grant($sformatf("rr[%0d]", i), seq_rr[i]);
        end

        // Weighted: requester 1 keeps three consecutive grants.
        do_reset();
        bus.weight_i  = wset(20'd0, 1, 2);
        bus.req_i     = 5'b00011;
        bus.gnt_ack_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk_grant($sformatf("wrr[%0d]", i), seq_w[i]);
        end

        // Pointer parked on 4, then wrap to 0.
        do_reset();
        bus.weight_i  = wset(20'd0, 4, 1);
        bus.req_i     = 5'b10000;
        bus.gnt_ack_i = 1'b1;
        tick();
        chk_grant("wrap_a", 4);
        tick();
        chk_grant("wrap_b", 4);
        chk("wrap ptr4", 32'(dut.ptr_reg), 32'd4);
        bus.req_i = 5'b00001;
        tick();
        chk_grant("wrap_c", 0);
        chk("wrap ptr0", 32'(dut.ptr_reg), 32'd0);

        // Grant held with no ack while requests and weights churn.
        do_reset();
        bus.weight_i = '0;
        bus.req_i    = 5'b01000;
        tick();
        chk_grant("hold_start", 3);
        for (int i = 0; i < 10; i++) begin
            bus.req_i    = (i % 2 == 0) ? 5'b10111 : 5'b00000;
            bus.weight_i = 20'($urandom);
            tick();
            chk(($sformatf("hold[%0d] num", i)), 32'(bus.gnt_num_o), 32'd3);
            chk(($sformatf("hold[%0d] val", i)), 32'(bus.gnt_val_o), 32'd1);
        end

        // Early turn end: grantee withdraws in its first ack cycle.
        do_reset();
        bus.weight_i = wset(20'd0, 2, 3);
        bus.req_i    = 5'b00100;
        tick();
        chk_grant("early_a", 2);
        bus.req_i     = 5'b11010;
        bus.gnt_ack_i = 1'b1;
        tick();
        chk_grant("early_b", 3);
        chk("early cnt", 32'(dut.cnt_reg), 32'd0);
        chk("early ptr", 32'(dut.ptr_reg), 32'd3);

        // Weight lowered below the running count ends the turn at that ack.
        do_reset();
        bus.weight_i  = wset(20'd0, 2, 3);
        bus.req_i     = 5'b00100;
        bus.gnt_ack_i = 1'b1;
        tick();
        chk_grant("lower_a", 2);
        tick();
        chk_grant("lower_b", 2);
        tick();
        chk_grant("lower_c", 2);
        chk("lower cnt2", 32'(dut.cnt_reg), 32'd2);
        bus.weight_i = wset(20'd0, 2, 1);
        bus.req_i    = 5'b01100;
        tick();
        chk_grant("lower_d", 3);
        chk("lower cnt0", 32'(dut.cnt_reg), 32'd0);

        bus.gnt_ack_i = 1'b0;
        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
